mul_pipe_signed: RTL and testbench
==================================

// Module: mul_pipe_signed
// PURPOSE
//  Parametrised, fully pipelined signed/unsigned integer multiplier for the CPU
//  execute stage (MULT/MULTU). Magnitude partial-product array feeds a registered
//  binary adder tree, then a sign-fix stage. One issue per clock, valid/ready
//  backpressure, mode selected per operation.
// PARAMETERS
//  WIDTH   32  operand width; power of two, 4..64
//  TAG_W   5   tag width, used only with MUL_TAG_EN (e.g. dest register index)
//  LAT     derived = clog2(WIDTH)+2; not overridable
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-low
//  in_valid   in   1        operation present on a/b/in_signed
//  in_ready   out  1        pipeline accepts this cycle
//  in_signed  in   1        1 = two's-complement operands, 0 = unsigned
//  a          in   WIDTH    multiplicand
//  b          in   WIDTH    multiplier
//  in_tag     in   TAG_W    (MUL_TAG_EN only) tag travelling with the operation
//  out_valid  out  1        out_p holds a result
//  out_ready  in   1        consumer takes result this cycle
//  out_p      out  2*WIDTH  product {hi,lo}
//  out_tag    out  TAG_W    (MUL_TAG_EN only) tag of the op on out_p
//  busy       out  1        any stage holds a valid op
// BEHAVIOUR
//  - Reset: the clock is clk; reset is asynchronous, active-low. All stage valid
//    bits, data registers, out_p and out_tag clear to 0; out_valid=0, busy=0.
//    Reset mid-operation discards all in-flight ops; no result is emitted afterwards.
//  - Global advance: adv = !out_valid | out_ready; in_ready = adv. All stages
//    shift together when adv=1 and hold when adv=0. No bubble collapsing.
//  - Accept: in_valid & in_ready. A bubble (valid=0) enters when in_valid=0.
//  - Stage 0: sign_a = in_signed & a[W-1], sign_b likewise. |a| = sign_a ? -a : a,
//    taken as a W-bit unsigned value (so -2^(W-1) gives 2^(W-1), no overflow).
//    Register |a|, |b|, neg = sign_a ^ sign_b, valid.
//  - Stage 1: WIDTH partial products pp[i] = |b|[i] ? (|a| << i) : 0, each 2W bits.
//  - Stages 2..clog2(W)+1: pairwise 2W-bit adder tree, one level per stage. Carries
//    beyond 2W bits are discarded; none occur for legal inputs.
//  - Final stage: out_p = neg ? (~sum + 1) : sum, across all 2W bits. 0 * neg
//    gives 0, never -0 garbage.
//  - Latency: result for an accepted op is valid exactly LAT advancing cycles later
//    (W=32: LAT=7). With out_ready tied 1, the pipeline sustains throughput 1/clk.
//  - out_valid=1 & out_ready=0 freezes the whole pipe, and out_p stays stable.
//    Same-cycle out_ready=1 & in_valid=1 drains one result and accepts one op.
//  - busy = OR of all stage valid bits, including out_valid.
//  - Unsigned mode: neg is forced to 0; out_p is the full 2W-bit unsigned product.
// CONFIGURATION
//  MUL_TAG_EN defined: in_tag/out_tag ports exist. The tag is registered alongside
//    valid in every stage and appears on out_tag in the same cycle as its out_p.
//    It resets to 0 and holds under stall.
//  MUL_TAG_EN undefined: in_tag/out_tag ports are absent and no tag registers exist.
//    Datapath, latency and handshake are identical to the defined case.
// TESTING
//  1. W=32, signed, a=-3 (0xFFFFFFFD), b=7 -> 7 cycles later out_p=0xFFFFFFFF_FFFFFFEB.
//  2. Signed a=b=0x80000000 -> out_p=0x40000000_00000000. Unsigned a=b=0xFFFFFFFF
//     -> 0xFFFFFFFE_00000001.
//  3. Back-to-back issue of 1*1, 2*3, 4*5 with out_ready=1 -> 1, 6, 20 on
//     consecutive cycles 7-9 after the first accept.
//  4. out_ready=0 for 5 cycles while 7 ops are in flight -> in_ready=0, out_p held,
//     no op lost or duplicated after release.
//  5. Assert reset at cycle 3 of an op -> outputs 0 asynchronously, busy=0, no
//     out_valid pulse ever appears for that op.
//  6. MUL_TAG_EN, tags 5,9 with stall in between -> out_tag 5 then 9, each aligned
//     with its product.

Source files
------------

// File: rtl/mul_pipe_signed.sv
// Pipelined signed/unsigned multiplier: magnitude partial products, registered adder tree, sign fix.
// Optional tag sideband travelling with each operation is enabled by defining MUL_TAG_EN.
`timescale 1ns/1ps
module mul_pipe_signed #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MUL_TAG_EN
  input  logic [TAG_W-1:0]   in_tag,
  output logic [TAG_W-1:0]   out_tag,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int LOGW = $clog2(WIDTH);
  localparam int LAT  = LOGW + 2;
  localparam int PW   = 2 * WIDTH;

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0 || TAG_W < 1) begin : g_bad_params
    $error("mul_pipe_signed: unsupported WIDTH or TAG_W");
  end

  logic             adv;
  logic [LAT:0]     vld;
  logic [LAT-1:0]   negp;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  // Heap-ordered tree: leaves WIDTH..PW-1 hold partial products, node n sums 2n and 2n+1.
  logic [PW-1:0]    node [1:PW-1];

  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[LAT];
  assign busy      = |vld;

  // The most negative value maps to 2^(W-1), which still fits as unsigned.
  assign sign_a = in_signed & a[WIDTH-1];
  assign sign_b = in_signed & b[WIDTH-1];
  assign a_mag  = sign_a ? -a : a;
  assign b_mag  = sign_b ? -b : b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld   <= '0;
      negp  <= '0;
      abs_a <= '0;
      abs_b <= '0;
      out_p <= '0;
      for (int n = 1; n < PW; n++) node[n] <= '0;
    end else if (adv) begin
      vld   <= {vld[LAT-1:0], in_valid};
      negp  <= {negp[LAT-2:0], sign_a ^ sign_b};
      abs_a <= a_mag;
      abs_b <= b_mag;
      for (int i = 0; i < WIDTH; i++)
        node[WIDTH+i] <= abs_b[i] ? ({{WIDTH{1'b0}}, abs_a} << i) : '0;
      for (int n = 1; n < WIDTH; n++)
        node[n] <= node[2*n] + node[2*n+1];
      out_p <= negp[LAT-1] ? -node[1] : node[1];
    end
  end

`ifdef MUL_TAG_EN
  logic [TAG_W-1:0] tagp [0:LAT];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= LAT; k++) tagp[k] <= '0;
    end else if (adv) begin
      tagp[0] <= in_tag;
      for (int k = 1; k <= LAT; k++) tagp[k] <= tagp[k-1];
    end
  end

  assign out_tag = tagp[LAT];
`endif

endmodule

// File: tb/tb_mul_pipe_signed.sv
// Directed self-checking bench for mul_pipe_signed at WIDTH=32 (LAT=7).
// Tag alignment is exercised only when MUL_TAG_EN is defined.
`timescale 1ns/1ps
module tb_mul_pipe_signed;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_p;
  logic        busy;
`ifdef MUL_TAG_EN
  logic [4:0]  in_tag;
  logic [4:0]  out_tag;
`endif

  int checks = 0;
  int fails  = 0;

  mul_pipe_signed #(.WIDTH(32), .TAG_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .a         (a),
    .b         (b),
`ifdef MUL_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic sgn, input logic [31:0] aa,
                               input logic [31:0] bb, input logic [4:0] tg);
    in_valid  = vld;
    in_signed = sgn;
    a         = aa;
    b         = bb;
`ifdef MUL_TAG_EN
    in_tag    = tg;
`else
    if (tg != 5'd0) $display("[TB] tag %0d ignored without MUL_TAG_EN", tg);
`endif
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Single op from an empty pipe: measure latency, check product, check it drains.
  task automatic runOne(input string name, input logic sgn, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [63:0] exp);
    int lat;
    applyStimulus(1'b1, sgn, aa, bb, 5'd0);
    stepCycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      stepCycle();
      lat++;
    end
    checkOutput({name, "_lat"}, 64'(lat), 64'd7);
    checkOutput({name, "_p"}, out_p, exp);
    stepCycle();
    checkOutput({name, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] stallExp [8];
    int idx;
    int pulses;

    reset     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    repeat (2) stepCycle();
    checkOutput("rst_out_p", out_p, 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
`ifdef MUL_TAG_EN
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
`endif
    reset = 1'b1;
    stepCycle();
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

    runOne("s_m3x7", 1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    runOne("u_m3x7", 1'b0, 32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB);
    runOne("s_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    runOne("u_max_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    runOne("s_max_min", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    runOne("s_m1_m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    runOne("s_zero_neg", 1'b1, 32'd0, 32'hFFFF_FFFB, 64'd0);

    // Back-to-back issue, results on consecutive cycles 7..9.
    applyStimulus(1'b1, 1'b0, 32'd1, 32'd1, 5'd0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'd2, 32'd3, 5'd0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'd4, 32'd5, 5'd0);
    stepCycle();
    in_valid = 1'b0;
    repeat (4) stepCycle();
    checkOutput("b2b_pre_valid", 64'(out_valid), 64'd0);
    stepCycle();
    checkOutput("b2b_v0", 64'(out_valid), 64'd1);
    checkOutput("b2b_p0", out_p, 64'd1);
    stepCycle();
    checkOutput("b2b_v1", 64'(out_valid), 64'd1);
    checkOutput("b2b_p1", out_p, 64'd6);
    stepCycle();
    checkOutput("b2b_v2", 64'(out_valid), 64'd1);
    checkOutput("b2b_p2", out_p, 64'd20);
    stepCycle();
    checkOutput("b2b_after", 64'(out_valid), 64'd0);

    // Seven ops in flight, five-cycle stall, then drain with a same-cycle accept.
    stallExp = '{64'd10, 64'd20, 64'd30, 64'd40, 64'd50, 64'd60, 64'd70, 64'd80};
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b1, 1'b0, 32'(i), 32'd10, 5'd0);
      stepCycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    stepCycle();
    for (int s = 0; s < 5; s++) begin
      checkOutput($sformatf("stall_in_ready%0d", s), 64'(in_ready), 64'd0);
      checkOutput($sformatf("stall_valid%0d", s), 64'(out_valid), 64'd1);
      checkOutput($sformatf("stall_hold%0d", s), out_p, 64'd10);
      stepCycle();
    end
    out_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd8, 32'd10, 5'd0);
    idx = 0;
    for (int n = 0; n < 40 && idx < 8; n++) begin
      if (out_valid) begin
        checkOutput($sformatf("stall_res%0d", idx), out_p, stallExp[idx]);
        idx++;
      end
      stepCycle();
      in_valid = 1'b0;
    end
    checkOutput("stall_count", 64'(idx), 64'd8);
    checkOutput("stall_empty_valid", 64'(out_valid), 64'd0);
    checkOutput("stall_empty_busy", 64'(busy), 64'd0);

    // Reset asserted in cycle 3 of an op; its result must never appear.
    applyStimulus(1'b1, 1'b1, 32'd1234, 32'd5678, 5'd0);
    stepCycle();
    in_valid = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("rst_mid_busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_mid_out_p", out_p, 64'd0);
    checkOutput("rst_mid_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    stepCycle();
    reset = 1'b1;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid) pulses++;
      stepCycle();
    end
    checkOutput("rst_mid_no_pulse", 64'(pulses), 64'd0);

`ifdef MUL_TAG_EN
    begin
      logic [63:0] tagExpP [2];
      logic [4:0]  tagExpT [2];
      tagExpP = '{64'd6, 64'd20};
      tagExpT = '{5'd5, 5'd9};
      applyStimulus(1'b1, 1'b0, 32'd2, 32'd3, 5'd5);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
      stepCycle();
      applyStimulus(1'b1, 1'b0, 32'd4, 32'd5, 5'd9);
      stepCycle();
      in_valid = 1'b0;
      idx = 0;
      for (int n = 0; n < 60 && idx < 2; n++) begin
        out_ready = ((n % 3) != 1);
        if (out_valid && out_ready) begin
          checkOutput($sformatf("tag_p%0d", idx), out_p, tagExpP[idx]);
          checkOutput($sformatf("tag_t%0d", idx), 64'(out_tag), 64'(tagExpT[idx]));
          idx++;
        end
        stepCycle();
      end
      out_ready = 1'b1;
      checkOutput("tag_count", 64'(idx), 64'd2);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
